// File: rtl/vga_scroll_pattern_gen.sv
// vga_scroll_pattern_gen: multi-mode scrolling VGA test pattern with registered, sync-matched output.
// Define PATTERN_NOISE_EN to replace the mode-3 solid colour with a per-frame LFSR noise field.
module vga_scroll_pattern_gen #(
    parameter int COLOR_BITS = 2,
    parameter int XW         = 10,
    parameter int YW         = 10,
    parameter int BAR_SHIFT  = 5,
    parameter int CHK_SHIFT  = 4,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XW-1:0]           hpos,
    input  logic [YW-1:0]           vpos,
    input  logic                    display_on,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic [1:0]              mode,
    input  logic [3:0]              speed,
    input  logic                    dir,
    input  logic                    pause,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    output logic [COLOR_BITS-1:0]   r_out,
    output logic [COLOR_BITS-1:0]   g_out,
    output logic [COLOR_BITS-1:0]   b_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic [XW-1:0]           scroll_pos,
    output logic [15:0]             frame_cnt
);
    localparam int CB = COLOR_BITS;

    logic            vs_q;
    logic            frame_tick;
    logic [1:0]      mode_q;
    logic [XW-1:0]   step;
    logic [XW-1:0]   mx;
    logic [XW-1:0]   d;
    logic            c;
    logic [3*CB-1:0] bars;
    logic [3*CB-1:0] chk;
    logic [3*CB-1:0] diag;
    logic [3*CB-1:0] solid;
    logic [3*CB-1:0] pix;

    // Frames are found by edge-detecting vsync in the pixel clock domain.
    assign frame_tick = (vsync_in == VSYNC_POL) && !vs_q;
    assign step       = XW'(speed);

`ifdef PATTERN_NOISE_EN
    logic [15:0] lfsr;

    // Re-seeding every frame makes the noise field identical frame to frame.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 16'hACE1;
        else if (frame_tick)
            lfsr <= 16'hACE1;
        else if (display_on)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign solid = {lfsr[0+:CB], lfsr[4+:CB], lfsr[8+:CB]};
`else
    assign solid = solid_rgb;
`endif

    always_comb begin
        mx   = hpos + scroll_pos;
        d    = mx + XW'(vpos);
        c    = mx[CHK_SHIFT] ^ vpos[CHK_SHIFT];
        bars = {{CB{mx[BAR_SHIFT]}}, {CB{mx[BAR_SHIFT+1]}}, {CB{mx[BAR_SHIFT+2]}}};
        chk  = {3*CB{c}};
        diag = {d[CHK_SHIFT+:CB], d[CHK_SHIFT+1+:CB], d[CHK_SHIFT+2+:CB]};
        pix  = !display_on  ? '0   :
               mode_q == 2'd0 ? bars :
               mode_q == 2'd1 ? chk  :
               mode_q == 2'd2 ? diag : solid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q       <= 1'b0;
            mode_q     <= 2'd0;
            scroll_pos <= '0;
            frame_cnt  <= '0;
            {r_out, g_out, b_out} <= '0;
            hsync_out  <= ~HSYNC_POL;
            vsync_out  <= ~VSYNC_POL;
        end else begin
            vs_q       <= (vsync_in == VSYNC_POL);
            {r_out, g_out, b_out} <= pix;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 16'd1;
                mode_q    <= mode;
                if (!pause)
                    scroll_pos <= dir ? scroll_pos - step : scroll_pos + step;
            end
        end
    end
endmodule

// File: tb/tb_vga_scroll_pattern_gen.sv
// tb_vga_scroll_pattern_gen: directed checks of patterns, scroll, pause, syncs and reset.
module tb_vga_scroll_pattern_gen;
    logic       clk = 0;
    logic       reset = 0;
    logic [9:0] hpos = 0;
    logic [9:0] vpos = 0;
    logic       display_on = 0;
    logic       hsync_in = 0;
    logic       vsync_in = 0;
    logic [1:0] mode = 0;
    logic [3:0] speed = 0;
    logic       dir = 0;
    logic       pause = 0;
    logic [5:0] solid_rgb = 0;
    logic [1:0] r_out, g_out, b_out;
    logic       hsync_out, vsync_out;
    logic [9:0] scroll_pos;
    logic [15:0] frame_cnt;
    int total = 0;
    int bad = 0;

    vga_scroll_pattern_gen dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .speed(speed), .dir(dir),
        .pause(pause), .solid_rgb(solid_rgb), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .scroll_pos(scroll_pos), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        vsync_in = 1;
        tick;
        vsync_in = 0;
        tick;
    endtask

    task automatic do_reset;
        reset = 1;
        tick;
        reset = 0;
    endtask

    task automatic test_reset;
        hsync_in = 1;
        vsync_in = 1;
        display_on = 1;
        hpos = 10'd255;
        reset = 1;
        tick;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'h00) begin bad++; $display("FAIL reset_rgb got=%h want=00", {r_out, g_out, b_out}); end
        total++;
        if ({hsync_out, vsync_out} !== 2'b00) begin bad++; $display("FAIL reset_syncs got=%b want=00", {hsync_out, vsync_out}); end
        total++;
        if (scroll_pos !== 10'd0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", scroll_pos, frame_cnt); end
        reset = 0;
        hsync_in = 0;
        vsync_in = 0;
        display_on = 0;
        hpos = 0;
        tick;
    endtask

    task automatic test_bars;
        mode = 0;
        speed = 0;
        pulse;
        display_on = 1;
        hpos = 10'd32;
        vpos = 0;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'b11_00_00) begin bad++; $display("FAIL bars_hpos32 got=%b want=110000", {r_out, g_out, b_out}); end
        total++;
        if (frame_cnt !== 16'd1) begin bad++; $display("FAIL bars_frame_cnt got=%0d want=1", frame_cnt); end
    endtask

    task automatic test_scroll;
        do_reset;
        speed = 3;
        dir = 0;
        pulse;
        pulse;
        total++;
        if (scroll_pos !== 10'd6) begin bad++; $display("FAIL scroll_fwd got=%0d want=6", scroll_pos); end
        dir = 1;
        speed = 7;
        pulse;
        total++;
        if (scroll_pos !== 10'd1023) begin bad++; $display("FAIL scroll_wrap got=%0d want=1023", scroll_pos); end
        display_on = 1;
        hpos = 10'd33;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'b11_00_00) begin bad++; $display("FAIL scroll_bars got=%b want=110000", {r_out, g_out, b_out}); end
        total++;
        if (frame_cnt !== 16'd3) begin bad++; $display("FAIL scroll_frame_cnt got=%0d want=3", frame_cnt); end
        dir = 0;
        speed = 0;
    endtask

    task automatic test_mode_switch;
        do_reset;
        display_on = 1;
        hpos = 10'd16;
        vpos = 0;
        mode = 1;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'h00) begin bad++; $display("FAIL midframe_still_bars got=%b want=000000", {r_out, g_out, b_out}); end
        pulse;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'h3F) begin bad++; $display("FAIL checker_after_tick got=%b want=111111", {r_out, g_out, b_out}); end
        vpos = 10'd16;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'h00) begin bad++; $display("FAIL checker_vpos16 got=%b want=000000", {r_out, g_out, b_out}); end
    endtask

    task automatic test_diag;
        do_reset;
        mode = 2;
        pulse;
        display_on = 1;
        hpos = 10'd100;
        vpos = 10'd50;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'b01_00_10) begin bad++; $display("FAIL diag_150 got=%b want=010010", {r_out, g_out, b_out}); end
    endtask

    task automatic test_blank_syncs;
        do_reset;
        mode = 3;
        solid_rgb = 6'h3F;
        display_on = 0;
        pulse;
        hpos = 10'd5;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'h00) begin bad++; $display("FAIL blank_rgb got=%h want=00", {r_out, g_out, b_out}); end
`ifndef PATTERN_NOISE_EN
        display_on = 1;
        solid_rgb = 6'b10_01_11;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'b10_01_11) begin bad++; $display("FAIL solid_rgb got=%b want=100111", {r_out, g_out, b_out}); end
        display_on = 0;
`endif
        hsync_in = 1;
        vsync_in = 0;
        tick;
        total++;
        if ({hsync_out, vsync_out} !== 2'b10) begin bad++; $display("FAIL sync_follow1 got=%b want=10", {hsync_out, vsync_out}); end
        hsync_in = 0;
        vsync_in = 1;
        #1;
        total++;
        if ({hsync_out, vsync_out} !== 2'b10) begin bad++; $display("FAIL sync_lag got=%b want=10", {hsync_out, vsync_out}); end
        tick;
        total++;
        if ({hsync_out, vsync_out} !== 2'b01) begin bad++; $display("FAIL sync_follow2 got=%b want=01", {hsync_out, vsync_out}); end
        vsync_in = 0;
        tick;
    endtask

    task automatic test_pause_reset;
        do_reset;
        mode = 0;
        speed = 5;
        pause = 0;
        pulse;
        pause = 1;
        pulse;
        pulse;
        pulse;
        total++;
        if (scroll_pos !== 10'd5) begin bad++; $display("FAIL pause_scroll got=%0d want=5", scroll_pos); end
        total++;
        if (frame_cnt !== 16'd4) begin bad++; $display("FAIL pause_frame_cnt got=%0d want=4", frame_cnt); end
        pause = 0;
        display_on = 1;
        hpos = 10'd27;
        hsync_in = 1;
        vsync_in = 1;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'b11_00_00) begin bad++; $display("FAIL preset_bars got=%b want=110000", {r_out, g_out, b_out}); end
        reset = 1;
        tick;
        total++;
        if ({r_out, g_out, b_out, hsync_out, vsync_out} !== 8'h00) begin bad++; $display("FAIL midline_reset_out got=%b want=00000000", {r_out, g_out, b_out, hsync_out, vsync_out}); end
        total++;
        if (scroll_pos !== 10'd0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL midline_reset_cnt got=%0d/%0d want=0/0", scroll_pos, frame_cnt); end
        reset = 0;
        hsync_in = 0;
        vsync_in = 0;
        hpos = 10'd32;
        tick;
        total++;
        if ({r_out, g_out, b_out} !== 6'b11_00_00) begin bad++; $display("FAIL resume_bars got=%b want=110000", {r_out, g_out, b_out}); end
        speed = 0;
    endtask

`ifdef PATTERN_NOISE_EN
    task automatic test_noise;
        logic [5:0] first [4];
        do_reset;
        mode = 3;
        display_on = 0;
        pulse;
        display_on = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            first[i] = {r_out, g_out, b_out};
        end
        total++;
        if (first[0] !== 6'b01_10_00) begin bad++; $display("FAIL noise_seed got=%b want=011000", first[0]); end
        total++;
        if (first[1] !== 6'b11_00_01) begin bad++; $display("FAIL noise_step got=%b want=110001", first[1]); end
        display_on = 0;
        pulse;
        display_on = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if ({r_out, g_out, b_out} !== first[i]) begin bad++; $display("FAIL noise_repeat%0d got=%b want=%b", i, {r_out, g_out, b_out}, first[i]); end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_bars;
        test_scroll;
        test_mode_switch;
        test_diag;
        test_blank_syncs;
        test_pause_reset;
`ifdef PATTERN_NOISE_EN
        test_noise;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
